// File: rtl/dct_sched_pkg.sv
// Shared types and constants for the 8-point DCT coefficient scheduler.
// DCT_SCHED_BLOCK_EN widens the fetch counter so one start covers an 8-row block.
package dct_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int N_PTS   = 8;
    localparam int ROM_LAT = 1;
    localparam int N_W     = $clog2(N_PTS);
    localparam int K_W     = $clog2(N_PTS);
    localparam int ROW_W   = $clog2(N_PTS);
    localparam int ADDR_W  = N_W + 1;

`ifdef DCT_SCHED_BLOCK_EN
    localparam int CNT_W = ROW_W + K_W + N_W;
`else
    localparam int CNT_W = K_W + N_W;
`endif

    // Pipeline payload: {last, k, n, clr, en}
    localparam int PIPE_W = 1 + K_W + N_W + 1 + 1;

    function automatic logic is_first_n(input logic [N_W-1:0] n);
        return n == {N_W{1'b0}};
    endfunction

    function automatic logic is_last_n(input logic [N_W-1:0] n);
        return n == {N_W{1'b1}};
    endfunction

endpackage

// File: rtl/dct_sched_dly.sv
// ROM_LAT-deep register chain that lines MAC controls up with coefficient ROM data.
module dct_sched_dly
    import dct_sched_pkg::*;
#(
    parameter int W     = PIPE_W,
    parameter int DEPTH = ROM_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe_r [DEPTH];

    // Shift chain; reset clears all stages so no stale enable survives an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= {W{1'b0}};
            end
        end else begin
            pipe_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign q = pipe_r[DEPTH-1];

endmodule

// File: rtl/dct_coef_sched.sv
// Address/MAC scheduler for an 8-point DCT: walks k=0..7, n=0..7 through the coefficient ROM.
// Optional DCT_SCHED_BLOCK_EN processes 8 rows per start and exposes row_idx.
module dct_coef_sched
    import dct_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [K_W-1:0]    rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [N_W-1:0]    mac_n,
    output logic              out_valid,
    output logic [K_W-1:0]    out_idx,
    output logic              done
`ifdef DCT_SCHED_BLOCK_EN
    ,
    output logic [ROW_W-1:0]  row_idx
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              accept_s;
    logic              fetch_s;
    logic              last_s;
    logic [PIPE_W-1:0] pipe_in_s;
    logic [PIPE_W-1:0] pipe_out_s;
    logic              mac_last_s;
    logic [K_W-1:0]    mac_k_s;
    logic              row_end_s;
    logic              busy_r;
    logic              out_valid_r;
    logic              done_r;
    logic [K_W-1:0]    out_idx_r;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign fetch_s  = (state_r == ST_FETCH);
    assign last_s   = fetch_s && (cnt_r == CNT_LAST);

    // Next-state decode; DRAIN waits for the final result to leave the MAC.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (done_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Fetch counter doubles as the ROM address register; it parks on its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (fetch_s && !last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pipe_in_s = {last_s,
                        cnt_r[K_W+N_W-1:N_W],
                        cnt_r[N_W-1:0],
                        fetch_s && is_first_n(cnt_r[N_W-1:0]),
                        fetch_s};

    dct_sched_dly #(
        .W     (PIPE_W),
        .DEPTH (ROM_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pipe_in_s),
        .q     (pipe_out_s)
    );

    assign {mac_last_s, mac_k_s, mac_n, mac_clr, mac_en} = pipe_out_s;
    assign row_end_s = mac_en && is_last_n(mac_n);

    // Result strobes trail the last accumulate of each k by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            out_idx_r   <= {K_W{1'b0}};
        end else begin
            busy_r      <= (state_nx_s != ST_IDLE);
            out_valid_r <= row_end_s;
            done_r      <= mac_en && mac_last_s;
            if (row_end_s) begin
                out_idx_r <= mac_k_s;
            end else begin
                out_idx_r <= out_idx_r;
            end
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign out_idx   = out_idx_r;
    assign rom_sel   = cnt_r[K_W+N_W-1:N_W];
    assign rom_addr  = {1'b0, cnt_r[N_W-1:0]};
`ifdef DCT_SCHED_BLOCK_EN
    assign row_idx   = cnt_r[CNT_W-1:K_W+N_W];
`endif

endmodule

// File: tb/tb_dct_coef_sched.sv
// Self-checking bench for dct_coef_sched: fixed-cycle table, corner sequences and random starts
// against a cycle-index reference model.
module tb_dct_coef_sched;

`ifdef DCT_SCHED_BLOCK_EN
    localparam int L = 512;
`else
    localparam int L = 64;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic [2:0] rom_sel;
    logic [3:0] rom_addr;
    logic       mac_en;
    logic       mac_clr;
    logic [2:0] mac_n;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       done;
`ifdef DCT_SCHED_BLOCK_EN
    logic [2:0] row_idx;
`endif

    dct_coef_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_n     (mac_n),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .done      (done)
`ifdef DCT_SCHED_BLOCK_EN
        ,
        .row_idx   (row_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int busy; int sel; int addr; int en; int clr; int n; int ov; int oidx; int done;
    } vec_t;

    typedef struct {
        int busy; int sel; int addr; int en; int clr; int n; int ov; int oidx; int done; int row;
    } snap_t;

    vec_t  tbl [12];
    snap_t snap [0:L+4];

    int n_cmp = 0;
    int n_bad = 0;
    // Model: mc is the cycle number within the current operation (1 = first address), 0 = never started.
    int mc = 0;
    bit ran = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, model cycle %0d)", nm, act, exp, $time, mc);
        end
    endtask

    function automatic int in_op();
        return (mc >= 1 && mc <= L + 2) ? 1 : 0;
    endfunction

    function automatic int e_sel();
        if (mc >= 1 && mc <= L) return ((mc - 1) / 8) % 8;
        return ran ? 7 : 0;
    endfunction

    function automatic int e_addr();
        if (mc >= 1 && mc <= L) return (mc - 1) % 8;
        return ran ? 7 : 0;
    endfunction

    function automatic int e_row();
        if (mc >= 1 && mc <= L) return (mc - 1) / 64;
        return ran ? 7 : 0;
    endfunction

    task automatic check_all();
        int en;
        int ov;
        en = (mc >= 2 && mc <= L + 1) ? 1 : 0;
        ov = (mc >= 10 && mc <= L + 2 && (mc - 10) % 8 == 0) ? 1 : 0;
        chk("busy", int'(busy), in_op());
        chk("rom_sel", int'(rom_sel), e_sel());
        chk("rom_addr", int'(rom_addr), e_addr());
        chk("mac_en", int'(mac_en), en);
        chk("mac_clr", int'(mac_clr), (en == 1 && (mc - 2) % 8 == 0) ? 1 : 0);
        if (en == 1) chk("mac_n", int'(mac_n), (mc - 2) % 8);
        chk("out_valid", int'(out_valid), ov);
        if (ov == 1) chk("out_idx", int'(out_idx), ((mc - 10) / 8) % 8);
        chk("done", int'(done), (mc == L + 2) ? 1 : 0);
`ifdef DCT_SCHED_BLOCK_EN
        chk("row_idx", int'(row_idx), e_row());
`endif
    endtask

    task automatic step(input logic st);
        start = st;
        @(posedge clk);
        if (rst_n) begin
            if (st && in_op() == 0) begin
                mc  = 1;
                ran = 1'b1;
            end else if (mc >= 1 && mc < L + 10) begin
                mc++;
            end
        end
        #1;
        check_all();
        start = 1'b0;
    endtask

    function automatic snap_t cap();
        snap_t s;
        s.busy = int'(busy);  s.sel = int'(rom_sel); s.addr = int'(rom_addr);
        s.en   = int'(mac_en); s.clr = int'(mac_clr); s.n = int'(mac_n);
        s.ov   = int'(out_valid); s.oidx = int'(out_idx); s.done = int'(done);
`ifdef DCT_SCHED_BLOCK_EN
        s.row  = int'(row_idx);
`else
        s.row  = 0;
`endif
        return s;
    endfunction

    // One full operation from idle; optionally a second start is held high during cycle 30.
    task automatic run_table(input bit poke30);
        int en_cnt;
        int clr_cnt;
        int ov_cnt;
        int done_cnt;
        int clr_bad;
        snap_t s;
        step(1'b1);
        snap[1] = cap();
        for (int i = 2; i <= L + 3; i++) begin
            step(poke30 && i == 31);
            snap[i] = cap();
        end
        foreach (tbl[r]) begin
            s = snap[tbl[r].cyc];
            chk($sformatf("tbl_busy@%0d", tbl[r].cyc), s.busy, tbl[r].busy);
            chk($sformatf("tbl_sel@%0d", tbl[r].cyc), s.sel, tbl[r].sel);
            chk($sformatf("tbl_addr@%0d", tbl[r].cyc), s.addr, tbl[r].addr);
            chk($sformatf("tbl_en@%0d", tbl[r].cyc), s.en, tbl[r].en);
            chk($sformatf("tbl_clr@%0d", tbl[r].cyc), s.clr, tbl[r].clr);
            if (tbl[r].en == 1) chk($sformatf("tbl_n@%0d", tbl[r].cyc), s.n, tbl[r].n);
            chk($sformatf("tbl_ov@%0d", tbl[r].cyc), s.ov, tbl[r].ov);
            if (tbl[r].ov == 1) chk($sformatf("tbl_oidx@%0d", tbl[r].cyc), s.oidx, tbl[r].oidx);
            chk($sformatf("tbl_done@%0d", tbl[r].cyc), s.done, tbl[r].done);
        end
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("first_addr@%0d", i), snap[i].addr, i - 1);
            chk($sformatf("first_sel@%0d", i), snap[i].sel, 0);
        end
        for (int i = 57; i <= 64; i++) chk($sformatf("k7_sel@%0d", i), snap[i].sel, 7);
        en_cnt = 0; clr_cnt = 0; ov_cnt = 0; done_cnt = 0; clr_bad = 0;
        for (int i = 1; i <= L + 3; i++) begin
            en_cnt   += snap[i].en;
            clr_cnt  += snap[i].clr;
            ov_cnt   += snap[i].ov;
            done_cnt += snap[i].done;
            if (snap[i].clr == 1 && !(i >= 2 && (i - 2) % 8 == 0)) clr_bad++;
        end
        chk("mac_en_count", en_cnt, L);
        chk("mac_clr_count", clr_cnt, L / 8);
        chk("mac_clr_misplaced", clr_bad, 0);
        chk("out_valid_count", ov_cnt, L / 8);
        chk("done_count", done_cnt, 1);
`ifdef DCT_SCHED_BLOCK_EN
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("row_idx@%0d", 1 + 64 * r), snap[1 + 64 * r].row, r);
            chk($sformatf("row_idx@%0d", 64 + 64 * r), snap[64 + 64 * r].row, r);
        end
`endif
    endtask

    initial begin
        tbl[0]  = '{1,     1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{2,     1, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{8,     1, 0, 7, 1, 0, 6, 0, 0, 0};
        tbl[3]  = '{9,     1, 1, 0, 1, 0, 7, 0, 0, 0};
        tbl[4]  = '{10,    1, 1, 1, 1, 1, 0, 1, 0, 0};
        tbl[5]  = '{18,    1, 2, 1, 1, 1, 0, 1, 1, 0};
        tbl[6]  = '{57,    1, 7, 0, 1, 0, 7, 0, 0, 0};
        tbl[7]  = '{58,    1, 7, 1, 1, 1, 0, 1, 6, 0};
        tbl[8]  = '{64,    1, 7, 7, 1, 0, 6, 0, 0, 0};
        tbl[9]  = '{L + 1, 1, 7, 7, 1, 0, 7, 0, 0, 0};
        tbl[10] = '{L + 2, 1, 7, 7, 0, 0, 0, 1, 7, 1};
        tbl[11] = '{L + 3, 0, 7, 7, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (3) step(1'b0);

        run_table(1'b0);
        repeat (3) step(1'b0);
        run_table(1'b1);

        // Back-to-back start in the first idle cycle, then reset in the middle of the row.
        step(1'b1);
        chk("restart_addr", int'(rom_addr), 0);
        chk("restart_sel", int'(rom_sel), 0);
        repeat (39) step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_mac_en", int'(mac_en), 0);
        chk("async_mac_clr", int'(mac_clr), 0);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_done", int'(done), 0);
        chk("async_rom_sel", int'(rom_sel), 0);
        chk("async_rom_addr", int'(rom_addr), 0);
        chk("async_mac_n", int'(mac_n), 0);
        chk("async_out_idx", int'(out_idx), 0);
        mc  = 0;
        ran = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        repeat (6) step(1'b0);
        step(1'b1);
        chk("post_reset_addr", int'(rom_addr), 0);
        chk("post_reset_sel", int'(rom_sel), 0);
        chk("post_reset_busy", int'(busy), 1);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
